// File: rtl/usb_dir_scheduler.sv
// Half-duplex direction scheduler for the shared 12 MHz bit datapath (NRZI, stuffing, CRC, DPLL).
// Optional TX watchdog: define USB_DIR_SCHED_TX_WATCHDOG_EN.

module usb_dir_scheduler #(
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned RESP_TIMEOUT  = 18,
    parameter int unsigned MAX_TX_CYCLES = 1200
) (
    input  logic clk12,
    input  logic RST_N,
    input  logic usbResetDetect,
    input  logic rxSyncDetect,
    input  logic rxEopDetect,
    input  logic rxDropPacket,
    input  logic txReq,
    input  logic txExpectResp,
    input  logic txDone,
    output logic outEN,
    output logic rxEnable,
    output logic dpllRST,
    output logic sharedRST,
    output logic selTx,
    output logic txGrant,
    output logic rxPacketDone,
    output logic rxPacketOk,
    output logic respTimeout,
    output logic txAbort,
    output logic busy
);

    localparam int unsigned CntMaxA = (GAP_CYCLES > RESP_TIMEOUT) ? GAP_CYCLES : RESP_TIMEOUT;
    localparam int unsigned CntMax  = (CntMaxA > MAX_TX_CYCLES) ? CntMaxA : MAX_TX_CYCLES;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] RespLast = CntW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRx,
        StRxGap,
        StTxSetup,
        StTx,
        StTxGap,
        StRespWait
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            resp_armed_q, resp_armed_d;

    logic gap_done;
    logic resp_done;
    logic wd_fire;

    logic out_en_d;
    logic rx_enable_d;
    logic dpll_rst_d;
    logic shared_rst_d;
    logic sel_tx_d;
    logic tx_grant_d;
    logic rx_packet_done_d;
    logic rx_packet_ok_d;
    logic resp_timeout_d;
    logic tx_abort_d;
    logic busy_d;

    assign gap_done  = (cnt_q == GapLast);
    assign resp_done = (cnt_q == RespLast);

`ifdef USB_DIR_SCHED_TX_WATCHDOG_EN
    localparam logic [CntW-1:0] TxLast = CntW'(MAX_TX_CYCLES - 1);

    assign wd_fire = (state_q == StTx) && !txDone && (cnt_q == TxLast);
`else
    assign wd_fire = 1'b0;
`endif

    // State register; every output is registered alongside the state.
    always_ff @(posedge clk12) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            resp_armed_q <= 1'b0;
            outEN        <= 1'b0;
            rxEnable     <= 1'b1;
            dpllRST      <= 1'b1;
            sharedRST    <= 1'b0;
            selTx        <= 1'b0;
            txGrant      <= 1'b0;
            rxPacketDone <= 1'b0;
            rxPacketOk   <= 1'b0;
            respTimeout  <= 1'b0;
            txAbort      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_armed_q <= resp_armed_d;
            outEN        <= out_en_d;
            rxEnable     <= rx_enable_d;
            dpllRST      <= dpll_rst_d;
            sharedRST    <= shared_rst_d;
            selTx        <= sel_tx_d;
            txGrant      <= tx_grant_d;
            rxPacketDone <= rx_packet_done_d;
            rxPacketOk   <= rx_packet_ok_d;
            respTimeout  <= resp_timeout_d;
            txAbort      <= tx_abort_d;
            busy         <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_armed_d = resp_armed_q;
        if (usbResetDetect) begin
            state_d      = StIdle;
            resp_armed_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rxSyncDetect) begin
                        state_d = StRx;
                    end else if (txReq) begin
                        state_d = StTxSetup;
                    end
                end
                StRx: begin
                    if (rxEopDetect) begin
                        state_d = StRxGap;
                    end
                end
                StRxGap: begin
                    if (gap_done) begin
                        state_d = StIdle;
                    end
                end
                StTxSetup: begin
                    state_d      = StTx;
                    resp_armed_d = txExpectResp;
                end
                StTx: begin
                    if (txDone) begin
                        state_d = StTxGap;
                    end else if (wd_fire) begin
                        state_d      = StTxGap;
                        resp_armed_d = 1'b0;
                    end
                end
                StTxGap: begin
                    if (gap_done) begin
                        state_d = resp_armed_q ? StRespWait : StIdle;
                    end
                end
                StRespWait: begin
                    if (rxSyncDetect) begin
                        state_d      = StRx;
                        resp_armed_d = 1'b0;
                    end else if (resp_done) begin
                        state_d      = StIdle;
                        resp_armed_d = 1'b0;
                    end
                end
                default: begin
                    state_d      = StIdle;
                    resp_armed_d = 1'b0;
                end
            endcase
        end

        // Counter restarts on every state change and saturates at all-ones.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        out_en_d         = (state_d == StTxSetup) || (state_d == StTx);
        sel_tx_d         = (state_d == StTxSetup) || (state_d == StTx) || (state_d == StTxGap);
        rx_enable_d      = !sel_tx_d;
        busy_d           = (state_d != StIdle);
        dpll_rst_d       = 1'b0;
        shared_rst_d     = 1'b0;
        tx_grant_d       = 1'b0;
        rx_packet_done_d = 1'b0;
        rx_packet_ok_d   = 1'b0;
        resp_timeout_d   = 1'b0;
        tx_abort_d       = 1'b0;

        // A bus reset suppresses every protocol-level pulse of this cycle.
        if (usbResetDetect) begin
            shared_rst_d = 1'b1;
            dpll_rst_d   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    shared_rst_d = !rxSyncDetect && txReq;
                end
                StRx: begin
                    if (rxEopDetect) begin
                        rx_packet_done_d = 1'b1;
                        rx_packet_ok_d   = !rxDropPacket;
                        shared_rst_d     = 1'b1;
                        dpll_rst_d       = 1'b1;
                    end
                end
                StTxSetup: begin
                    tx_grant_d = 1'b1;
                end
                StTx: begin
                    shared_rst_d = txDone || wd_fire;
                    tx_abort_d   = wd_fire;
                end
                StTxGap: begin
                    dpll_rst_d = gap_done && resp_armed_q;
                end
                StRespWait: begin
                    resp_timeout_d = !rxSyncDetect && resp_done;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
